// File: rtl/sms_pkg.sv
// sms_pkg: shared cartridge-loader state encoding and constants.
package sms_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_BYTE, WRITE, DRAIN, DONE} state_t;
  localparam int HDR_BYTES = 512;
  localparam logic [4:0] GG_INDEX = 5'd2;
endpackage

// File: rtl/cart_loader_if.sv
// cart_loader_if: HPS ioctl download stream, SDRAM write port and cartridge status.
interface cart_loader_if #(parameter int AW = 22, parameter int WAW = 24);
  logic           ioctl_download;
  logic [7:0]     ioctl_index;
  logic           ioctl_wr;
  logic [24:0]    ioctl_addr;
  logic [7:0]     ioctl_dout;
  logic           ioctl_wait;
  logic           sd_we;
  logic           sd_we_ack;
  logic [WAW-1:0] sd_waddr;
  logic [7:0]     sd_din;
  logic [AW-1:0]  cart_mask;
  logic [AW-1:0]  cart_mask512;
  logic           hdr512;
  logic           gg;
  logic           load_done;
  logic           overrun;
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
    input  ioctl_wait, sd_we, sd_waddr, sd_din, cart_mask, cart_mask512, hdr512, gg,
           load_done, overrun
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sd_we_ack,
    output ioctl_wait, sd_we, sd_waddr, sd_din, cart_mask, cart_mask512, hdr512, gg,
           load_done, overrun
  );
endinterface

// File: rtl/cart_loader_toggle_req.sv
// toggle_req: toggle-handshake request with ack compare, ack ignored until first arm.
module toggle_req (
  input  logic clk_sys,
  input  logic RESET_n,
  input  logic i_arm,
  input  logic i_fire,
  input  logic i_ack,
  output logic o_req,
  output logic o_done
);
  logic r_req, r_trust;
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      r_req   <= 1'b0;
      r_trust <= 1'b0;
    end else begin
      if (i_fire) r_req <= ~r_req;
      if (i_arm) r_trust <= 1'b1;
    end
  assign o_req  = r_req;
  assign o_done = r_trust && (i_ack == r_req);
endmodule

// File: rtl/cart_loader.sv
// cart_loader: turns ioctl download bytes into toggle-handshake SDRAM writes and tracks cart masks.
module cart_loader import sms_pkg::*; #(
  parameter int AW  = 22,
  parameter int WAW = 24
) (
  input logic         clk_sys,
  input logic         RESET_n,
  cart_loader_if.slave bus
);
  state_t r_state, w_next;
  logic r_dl_d, r_pend;
  logic w_rise, w_arm, w_accept, w_ackd, w_ovr, w_fin, w_done;
  logic [AW-1:0] w_off;
  logic r_wait, r_hdr, r_gg, r_load_done, r_ovr;
  logic [WAW-1:0] r_waddr;
  logic [7:0] r_din;
  logic [AW-1:0] r_mask, r_mask512;
  toggle_req u_req (
    .clk_sys(clk_sys),
    .RESET_n(RESET_n),
    .i_arm(w_arm),
    .i_fire(w_accept),
    .i_ack(bus.sd_we_ack),
    .o_req(bus.sd_we),
    .o_done(w_done)
  );
  // a rise seen outside IDLE is held so it is taken once the FSM returns
  assign w_rise = (bus.ioctl_download && !r_dl_d) || r_pend;
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      r_state <= IDLE;
      r_dl_d  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dl_d  <= bus.ioctl_download;
      r_pend  <= w_rise && bus.ioctl_download && r_state != IDLE;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_rise ? ARM : IDLE;
      ARM:       w_next = WAIT_BYTE;
      WAIT_BYTE: w_next = !bus.ioctl_download ? DONE : bus.ioctl_wr ? WRITE : WAIT_BYTE;
      WRITE:     w_next = w_done ? WAIT_BYTE : !bus.ioctl_download ? DRAIN : WRITE;
      DRAIN:     w_next = w_done ? DONE : DRAIN;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_arm    = r_state == ARM;
    w_accept = r_state == WAIT_BYTE && bus.ioctl_download && bus.ioctl_wr;
    w_ackd   = (r_state == WRITE || r_state == DRAIN) && w_done;
    w_ovr    = r_state == WRITE && bus.ioctl_wr;
    w_fin    = r_state == DONE;
    w_off    = bus.ioctl_addr[AW-1:0] - AW'(HDR_BYTES);
  end
  always_ff @(posedge clk_sys or negedge RESET_n)
    if (!RESET_n) begin
      r_wait      <= 1'b0;
      r_waddr     <= '0;
      r_din       <= '0;
      r_mask      <= '0;
      r_mask512   <= '0;
      r_hdr       <= 1'b0;
      r_gg        <= 1'b0;
      r_load_done <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_load_done <= w_fin;
      if (w_arm) begin
        r_waddr   <= '0;
        r_mask    <= '0;
        r_mask512 <= '0;
        r_hdr     <= 1'b0;
        r_ovr     <= 1'b0;
        r_gg      <= bus.ioctl_index[4:0] == GG_INDEX;
      end
      if (w_accept) begin
        r_din  <= bus.ioctl_dout;
        r_wait <= 1'b1;
        r_mask <= r_mask | bus.ioctl_addr[AW-1:0];
        if (bus.ioctl_addr >= 25'(HDR_BYTES)) r_mask512 <= r_mask512 | w_off;
      end
      if (w_ackd) begin
        r_wait  <= 1'b0;
        r_waddr <= r_waddr + 1'b1;
      end
      if (w_ovr) r_ovr <= 1'b1;
      if (w_fin) r_hdr <= r_waddr[9:0] == 10'(HDR_BYTES);
    end
  assign bus.ioctl_wait   = r_wait;
  assign bus.sd_waddr     = r_waddr;
  assign bus.sd_din       = r_din;
  assign bus.cart_mask    = r_mask;
  assign bus.cart_mask512 = r_mask512;
  assign bus.hdr512       = r_hdr;
  assign bus.gg           = r_gg;
  assign bus.load_done    = r_load_done;
  assign bus.overrun      = r_ovr;
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: randomized downloads against an SDRAM ack model and a mask/write-log reference.
module tb_cart_loader;
  localparam int AW = 22, WAW = 24;
  logic clk_sys = 1'b0, rst_n = 1'b0;
  always #5 clk_sys = ~clk_sys;
  cart_loader_if #(.AW(AW), .WAW(WAW)) bus ();
  cart_loader #(.AW(AW), .WAW(WAW)) dut (.clk_sys(clk_sys), .RESET_n(rst_n), .bus(bus));
  int n_chk = 0, n_fail = 0;
  int ack_dly = 1, exp_run = 2;
  logic [15:0] ack_sr;
  logic prev_we;
  int run = 0, tog_total = 0, done_total = 0, late_total = 0, runs_total = 0, bad_runs = 0;
  logic [WAW-1:0] log_a [16384];
  logic [7:0] log_d [16384];
  logic [7:0] src [4096];
  int tog0, done0, late0, runs0, bad0;
  // SDRAM side: ack follows the request after ack_dly clocks
  assign bus.sd_we_ack = ack_sr[ack_dly-1];
  always @(posedge clk_sys or negedge rst_n)
    if (!rst_n) ack_sr <= '0;
    else ack_sr <= {ack_sr[14:0], bus.sd_we};
  always @(negedge clk_sys)
    if (!rst_n) begin
      prev_we <= 1'b0;
      run <= 0;
    end else begin
      if (bus.sd_we != prev_we) begin
        log_a[tog_total & 16383] <= bus.sd_waddr;
        log_d[tog_total & 16383] <= bus.sd_din;
        tog_total <= tog_total + 1;
        prev_we <= bus.sd_we;
      end
      if (bus.ioctl_wait) run <= run + 1;
      else if (run != 0) begin
        runs_total <= runs_total + 1;
        if (run != exp_run) bad_runs <= bad_runs + 1;
        run <= 0;
      end
      if (bus.load_done) begin
        done_total <= done_total + 1;
        if (bus.sd_we_ack != bus.sd_we) late_total <= late_total + 1;
      end
    end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint mask_of(input int n, input int base);
    longint m = 0;
    for (int a = base; a < n; a++) m |= longint'(a - base);
    return m & ((longint'(1) << AW) - 1);
  endfunction
  task automatic start_dl(input logic [7:0] idx, input int dly);
    ack_dly = dly;
    exp_run = dly + 1;
    tog0 = tog_total; done0 = done_total; late0 = late_total;
    runs0 = runs_total; bad0 = bad_runs;
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask
  task automatic wait_idle();
    for (int b = 0; b < 64 && bus.ioctl_wait; b++) begin
      @(posedge clk_sys);
      #1;
    end
    if (bus.ioctl_wait) chk("wait_bound", longint'(bus.ioctl_wait), 0);
  endtask
  task automatic send(input int a, input bit do_wait);
    src[a] = 8'($urandom);
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = src[a];
    bus.ioctl_wr = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr = 1'b0;
    if (do_wait) wait_idle();
  endtask
  task automatic end_dl(output int lat);
    bus.ioctl_download = 1'b0;
    lat = 0;
    while (!bus.load_done && lat < 64) begin
      @(negedge clk_sys);
      lat++;
    end
    if (!bus.load_done) chk("done_bound", longint'(bus.load_done), 1);
    repeat (3) @(posedge clk_sys);
    #1;
  endtask
  task automatic verify(input int n, input logic [7:0] idx);
    int errs = 0;
    for (int k = 0; k < n; k++)
      if (log_a[(tog0 + k) & 16383] != WAW'(k) || log_d[(tog0 + k) & 16383] != src[k]) errs++;
    chk("toggles", tog_total - tog0, n);
    chk("done_pulses", done_total - done0, 1);
    chk("waddr_end", bus.sd_waddr, n);
    chk("write_seq", errs, 0);
    chk("cart_mask", bus.cart_mask, mask_of(n, 0));
    chk("cart_mask512", bus.cart_mask512, mask_of(n, 512));
    chk("hdr512", bus.hdr512, (n % 1024) == 512);
    chk("gg", bus.gg, idx[4:0] == 5'd2);
    chk("wait_len", bad_runs - bad0, 0);
    chk("wait_end", bus.ioctl_wait, 0);
  endtask
  initial begin
    logic [7:0] idx;
    int lat, d;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = '0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_wait", bus.ioctl_wait, 0);
    chk("rst_we", bus.sd_we, 0);
    chk("rst_waddr", bus.sd_waddr, 0);
    chk("rst_din", bus.sd_din, 0);
    chk("rst_masks", {bus.cart_mask, bus.cart_mask512}, 0);
    chk("rst_flags", {bus.hdr512, bus.gg, bus.load_done, bus.overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    // plain image, fastest ack
    idx = 8'($urandom);
    if (idx[4:0] == 5'd2) idx[0] = ~idx[0];
    start_dl(idx, 1);
    for (int a = 0; a < 2048; a++) send(a, 1'b1);
    end_dl(lat);
    chk("done_lat", lat, 3);
    verify(2048, idx);
    chk("overrun_clear", bus.overrun, 0);
    // GG image with copier header, random ack delay
    idx = {3'($urandom), 5'd2};
    d = $urandom_range(1, 3);
    start_dl(idx, d);
    for (int a = 0; a < 2560; a++) send(a, 1'b1);
    end_dl(lat);
    chk("done_lat_gg", lat, 3);
    verify(2560, idx);
    // slow ack: wait must stay high 8 cycles per byte
    idx = 8'($urandom);
    start_dl(idx, 7);
    for (int a = 0; a < 64; a++) send(a, 1'b1);
    end_dl(lat);
    verify(64, idx);
    chk("wait_runs", runs_total - runs0, 64);
    // extra strobe while a write is pending is dropped
    idx = 8'($urandom);
    start_dl(idx, 7);
    for (int a = 0; a < 16; a++) begin
      if (a == 5) begin
        send(a, 1'b0);
        bus.ioctl_addr = 25'd100;
        bus.ioctl_dout = ~src[a];
        bus.ioctl_wr = 1'b1;
        @(posedge clk_sys);
        #1;
        bus.ioctl_wr = 1'b0;
        wait_idle();
      end else send(a, 1'b1);
    end
    chk("overrun_set", bus.overrun, 1);
    end_dl(lat);
    verify(16, idx);
    // download falls with an ack outstanding
    idx = 8'($urandom);
    start_dl(idx, 7);
    for (int a = 0; a < 7; a++) send(a, 1'b1);
    send(7, 1'b0);
    end_dl(lat);
    chk("drain_lat", lat, 10);
    chk("drain_ack", late_total - late0, 0);
    verify(8, idx);
    // reset mid-transfer, then a fresh download
    start_dl({3'($urandom), 5'd2}, 7);
    for (int a = 0; a < 5; a++) send(a, 1'b1);
    send(5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_wait_we", {bus.ioctl_wait, bus.sd_we}, 0);
    chk("abort_waddr", bus.sd_waddr, 0);
    chk("abort_mask", bus.cart_mask, 0);
    chk("abort_flags", {bus.gg, bus.hdr512, bus.load_done, bus.overrun}, 0);
    bus.ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    idx = 8'($urandom);
    start_dl(idx, $urandom_range(1, 4));
    for (int a = 0; a < 40; a++) send(a, 1'b1);
    end_dl(lat);
    chk("done_lat_rst", lat, 3);
    verify(40, idx);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
